pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Central pipeline controller that drives the hold/stall controls of the if_id and id_ex pipeline registers and the PC.
- Combines jump flushes from EX, load-use hazards between ID and EX, multi-cycle EX busy, bus-arbiter hold and CLINT interrupt hold into one priority-encoded hold_flag_o plus a one-cycle stall_flag_o.
- Contains a small FSM that guarantees single-cycle load-use stalls and a busy-timeout watchdog.

Parameters:
- BUSY_TIMEOUT, 64, max consecutive ex_busy_i cycles before busy_timeout_o sets; legal range 2..255.
- TO_W, 8, watchdog counter width; must satisfy 2^TO_W > BUSY_TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- jump_flag_i  in  1  EX redirect request
- jump_addr_i  in  32  EX redirect target
- ex_busy_i  in  1  multi-cycle EX op (div) in progress
- rib_hold_i  in  1  bus arbiter requests PC hold
- clint_hold_i  in  1  interrupt controller requests pipeline hold
- id_rs1_i  in  5  ID source reg 1 address
- id_rs2_i  in  5  ID source reg 2 address
- id_rs1_re_i  in  1  ID reads rs1
- id_rs2_re_i  in  1  ID reads rs2
- ex_is_load_i  in  1  instruction in EX is a load
- ex_rd_i  in  5  EX destination reg
- ex_we_i  in  1  EX writes rd
- hold_flag_o  out  3  Hold_None/Hold_Pc/Hold_If/Hold_Id
- stall_flag_o  out  1  freeze id_ex contents this cycle
- jump_flag_o  out  1  redirect to PC
- jump_addr_o  out  32  redirect target
- busy_timeout_o  out  1  sticky watchdog error

Behaviour:
- Reset (rst=0 at posedge): FSM to IDLE, watchdog count 0, busy_timeout_o 0, perf counters 0.
- While rst=0, all combinational outputs are forced inactive: hold_flag_o=Hold_None, stall_flag_o=0, jump_flag_o=0, jump_addr_o=0.
- Hazard: haz = ex_is_load_i & ex_we_i & (ex_rd_i!=0) & ((id_rs1_re_i & id_rs1_i==ex_rd_i) | (id_rs2_re_i & id_rs2_i==ex_rd_i)).
- FSM states:
  - IDLE: haz & !jump_flag_i -> LDUSE.
  - LDUSE: lasts exactly 1 cycle, then -> IDLE unconditionally. haz is ignored while in LDUSE, so a second stall of the same pair is impossible.
  - BUSY: entered from IDLE when ex_busy_i=1 (priority over haz). Leaves to IDLE on the cycle ex_busy_i=0.
- stall_flag_o = (state==IDLE) & haz & !jump_flag_i & !ex_busy_i. This is combinational in the detect cycle; exactly one cycle per hazard.
- hold_flag_o, combinational, highest priority first:
  1. jump_flag_i | clint_hold_i | ex_busy_i -> Hold_Id.
  2. stall_flag_o -> Hold_If (PC and if_id frozen while id_ex self-holds).
  3. rib_hold_i -> Hold_Pc.
  4. otherwise -> Hold_None.
- jump_flag_o = jump_flag_i; jump_addr_o = jump_addr_i when jump_flag_i, else 0. Zero latency.
- Jump during LDUSE: jump wins; hold_flag_o=Hold_Id; FSM still returns to IDLE next cycle.
- Watchdog: counter increments each cycle ex_busy_i=1 and saturates at BUSY_TIMEOUT; it clears when ex_busy_i=0. When count==BUSY_TIMEOUT, busy_timeout_o sets on the next edge and stays set until reset.
- Reset mid-stall or mid-busy: FSM returns to IDLE and no residual stall is issued.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- Defined: adds two 32-bit wrapping counters, stall_cnt_o and hold_cnt_o.
  - stall_cnt_o increments on each stall_flag_o cycle.
  - hold_cnt_o increments on each cycle with hold_flag_o != Hold_None.
  - Both reset to 0.
  - Both appear as extra output ports at the end of the port list.
- Undefined: ports and logic are absent; the remaining behaviour is identical.

Decomposition:
- Shared defines header (existing): Hold_Flag_Bus, Hold_None=3'b000, Hold_Pc=3'b001, Hold_If=3'b010, Hold_Id=3'b011, ZeroWord, ZeroReg, RegAddrBus. Add FSM state encodings PHC_IDLE/PHC_LDUSE/PHC_BUSY there.
- One natural sub-module: pipe_busy_wdog, holding the watchdog counter and sticky flag.

Test Plan:
- Load-use: EX lw x5 (ex_is_load_i=1, ex_we_i=1, ex_rd_i=5), ID add with id_rs1_i=5, id_rs1_re_i=1 -> stall_flag_o=1 and hold_flag_o=Hold_If for exactly 1 cycle; the next cycle, with the same inputs, stall_flag_o=0.
- ex_rd_i=0 with the same load pattern -> no stall.
- Jump plus hazard in the same cycle: jump_flag_i=1, jump_addr_i=32'h0000_0100 -> hold_flag_o=Hold_Id, stall_flag_o=0, jump_addr_o=32'h100.
- ex_busy_i high for 33 cycles (BUSY_TIMEOUT=64) -> hold_flag_o=Hold_Id throughout, busy_timeout_o=0; returns to Hold_None after busy drops.
- ex_busy_i high for 70 cycles -> busy_timeout_o rises at the edge after the count reaches 64 and stays 1 after busy drops, until rst=0.
- rib_hold_i=1 alone -> Hold_Pc. Then assert rst=0 during a LDUSE cycle -> on the next cycle all outputs are inactive and the FSM is in IDLE. With PIPE_PERF_CNT_EN defined, stall_cnt_o=1 after the first scenario.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared hold-flag encodings, register/word constants and FSM states for the
// pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

    typedef logic [2:0]  hold_flag_bus_t;
    typedef logic [4:0]  reg_addr_bus_t;

    localparam hold_flag_bus_t Hold_None = 3'b000;
    localparam hold_flag_bus_t Hold_Pc   = 3'b001;
    localparam hold_flag_bus_t Hold_If   = 3'b010;
    localparam hold_flag_bus_t Hold_Id   = 3'b011;

    localparam logic [31:0]   ZeroWord = 32'h0000_0000;
    localparam reg_addr_bus_t ZeroReg  = 5'd0;

    typedef enum logic [1:0] {
        PHC_IDLE  = 2'd0,
        PHC_LDUSE = 2'd1,
        PHC_BUSY  = 2'd2
    } phc_state_e;

    // A load in EX whose result is needed by the instruction now in ID.
    function automatic logic load_use_haz(
        input logic          ex_is_load,
        input logic          ex_we,
        input reg_addr_bus_t ex_rd,
        input logic          rs1_re,
        input reg_addr_bus_t rs1,
        input logic          rs2_re,
        input reg_addr_bus_t rs2
    );
        return ex_is_load & ex_we & (ex_rd != ZeroReg) &
               ((rs1_re & (rs1 == ex_rd)) | (rs2_re & (rs2 == ex_rd)));
    endfunction

endpackage

// File: rtl/pipe_busy_wdog.sv
// Busy watchdog: counts consecutive ex_busy_i cycles (saturating) and raises a
// sticky error once the count has sat at BUSY_TIMEOUT for an edge.
module pipe_busy_wdog #(
    parameter int BUSY_TIMEOUT = 64,
    parameter int TO_W         = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ex_busy_i,
    output logic busy_timeout_o
);

    localparam logic [TO_W-1:0] Limit = TO_W'(BUSY_TIMEOUT);

    logic [TO_W-1:0] busy_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_cnt       <= '0;
            busy_timeout_o <= 1'b0;
        end else begin
            if (busy_cnt == Limit) begin
                busy_timeout_o <= 1'b1;
            end
            if (!ex_busy_i) begin
                busy_cnt <= '0;
            end else if (busy_cnt != Limit) begin
                busy_cnt <= busy_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline hold/stall controller: jump, load-use, busy, bus and
// interrupt holds. Optional perf counters under `define PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int BUSY_TIMEOUT = 64,
    parameter int TO_W         = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 jump_flag_i,
    input  logic [31:0]          jump_addr_i,
    input  logic                 ex_busy_i,
    input  logic                 rib_hold_i,
    input  logic                 clint_hold_i,
    input  logic [4:0]           id_rs1_i,
    input  logic [4:0]           id_rs2_i,
    input  logic                 id_rs1_re_i,
    input  logic                 id_rs2_re_i,
    input  logic                 ex_is_load_i,
    input  logic [4:0]           ex_rd_i,
    input  logic                 ex_we_i,
    output logic [2:0]           hold_flag_o,
    output logic                 stall_flag_o,
    output logic                 jump_flag_o,
    output logic [31:0]          jump_addr_o,
    output logic                 busy_timeout_o
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]          stall_cnt_o,
    output logic [31:0]          hold_cnt_o
`endif
);

    phc_state_e state;
    logic       haz;

    assign haz = load_use_haz(ex_is_load_i, ex_we_i, ex_rd_i,
                              id_rs1_re_i, id_rs1_i, id_rs2_re_i, id_rs2_i);

    // LDUSE lasts one cycle so the same producer/consumer pair never stalls twice.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= PHC_IDLE;
        end else begin
            case (state)
                PHC_IDLE: begin
                    if (ex_busy_i) begin
                        state <= PHC_BUSY;
                    end else if (haz && !jump_flag_i) begin
                        state <= PHC_LDUSE;
                    end
                end
                PHC_LDUSE: state <= PHC_IDLE;
                PHC_BUSY: begin
                    if (!ex_busy_i) begin
                        state <= PHC_IDLE;
                    end
                end
                default: state <= PHC_IDLE;
            endcase
        end
    end

    always_comb begin
        stall_flag_o = rst & (state == PHC_IDLE) & haz & ~jump_flag_i & ~ex_busy_i;
        hold_flag_o  = Hold_None;
        if (rst) begin
            if (jump_flag_i || clint_hold_i || ex_busy_i) begin
                hold_flag_o = Hold_Id;
            end else if (stall_flag_o) begin
                hold_flag_o = Hold_If;
            end else if (rib_hold_i) begin
                hold_flag_o = Hold_Pc;
            end
        end
    end

    assign jump_flag_o = rst & jump_flag_i;
    assign jump_addr_o = (rst && jump_flag_i) ? jump_addr_i : ZeroWord;

    pipe_busy_wdog #(
        .BUSY_TIMEOUT (BUSY_TIMEOUT),
        .TO_W         (TO_W)
    ) u_wdog (
        .clk            (clk),
        .rst            (rst),
        .ex_busy_i      (ex_busy_i),
        .busy_timeout_o (busy_timeout_o)
    );

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_o <= '0;
            hold_cnt_o  <= '0;
        end else begin
            if (stall_flag_o) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (hold_flag_o != Hold_None) begin
                hold_cnt_o <= hold_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule
